// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared defaults, id-width derivation and occupancy encodings
package adder_arbiter_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int NUM_REQ_DEF = 3;

    // Index width for a requester count, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } occ_t;

endpackage

// File: rtl/adder_arbiter_rr_grant.sv
// rtl/adder_arbiter_rr_grant.sv - round-robin one-hot grant starting at ptr
module rr_grant #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic found;

    // Pass one covers ptr..NUM_REQ-1; pass two wraps around to 0..ptr-1.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - one shared adder arbitrated round-robin among requesters
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic [WIDTH-1:0]           resp_result,
    output logic                       resp_carry,
    output logic                       resp_ovf
);

    occ_t             state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [NUM_REQ-1:0] gnt;
    logic               accept;
    logic [ID_W-1:0]    win_id;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [WIDTH:0]     sum;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_grant (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // Winner selection uses only the one-hot grant, so operands never feed req_ready.
    always_comb begin
        win_id = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_id = ID_W'(i);
                a_sel  = req_a[i*WIDTH +: WIDTH];
                b_sel  = req_b[i*WIDTH +: WIDTH];
            end
        end
        sum = {1'b0, a_sel} + {1'b0, b_sel};
    end

    always_comb begin
        accept    = !reset && (|req_valid) && ((state_q == EMPTY) || resp_ready);
        req_ready = accept ? gnt : '0;
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        result_d  = result_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        if (accept) begin
            state_d  = FULL;
            ptr_d    = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
            id_d     = win_id;
            result_d = sum[WIDTH-1:0];
            carry_d  = sum[WIDTH];
            ovf_d    = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) && (sum[WIDTH-1] != a_sel[WIDTH-1]);
        end else if ((state_q == FULL) && resp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            ptr_q    <= '0;
            id_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign resp_valid  = (state_q == FULL);
    assign resp_id     = id_q;
    assign resp_result = result_q;
    assign resp_carry  = carry_q;
    assign resp_ovf    = ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - scoreboard bench for adder_arbiter with directed vectors
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_ready;
    logic [95:0] req_a = '0;
    logic [95:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [1:0]  resp_id;
    logic [31:0] resp_result;
    logic        resp_carry;
    logic        resp_ovf;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] res;
        logic        c;
        logic        o;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    adder_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_carry  (resp_carry),
        .resp_ovf    (resp_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every consumed response is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", {resp_id, resp_result, resp_carry, resp_ovf}, 64'hdead);
            end else begin
                e = q.pop_front();
                chk("resp", {resp_id, resp_result, resp_carry, resp_ovf}, e);
            end
        end
    end

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    // Entered at posedge+1; leaves at the next posedge+1.
    task automatic step(input logic [2:0] v, input logic rr, input logic [2:0] exp_rdy,
                        input logic [1:0] eid, input logic [31:0] eres, input logic ec, input logic eo);
        exp_t e;
        req_valid  = v;
        resp_ready = rr;
        #3;
        chk("req_ready", {61'd0, req_ready}, {61'd0, exp_rdy});
        if (exp_rdy != 3'b000) begin
            e = {eid, eres, ec, eo};
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hold_step(input logic [1:0] eid, input logic [31:0] eres);
        req_valid  = 3'b010;
        resp_ready = 1'b0;
        #3;
        chk("hold_ready", {61'd0, req_ready}, 64'd0);
        chk("hold_valid", {63'd0, resp_valid}, 64'd1);
        chk("hold_resp", {resp_id, resp_result}, {eid, eres});
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values;
        chk("rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp", {resp_id, resp_result, resp_carry, resp_ovf}, 64'd0);
    endtask

    task automatic check_idle;
        chk("idle_valid", {63'd0, resp_valid}, 64'd0);
    endtask

    // Reset held one cycle with the given requests pending; pending result is discarded.
    task automatic pulse_reset(input logic [2:0] v, input logic rr);
        reset      = 1'b1;
        req_valid  = v;
        resp_ready = rr;
        #3;
        chk("rst_ready", {61'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        check_reset_values();
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        #3;
        chk("rst_ready_init", {61'd0, req_ready}, 64'd0);
        reset = 1'b0;
        check_reset_values();

        // Single request from requester 0.
        set_ops(0, 32'd5, 32'd7);
        step(3'b001, 1'b1, 3'b001, 2'd0, 32'd12, 1'b0, 1'b0);
        step(3'b000, 1'b1, 3'b000, 2'd0, 32'd0, 1'b0, 1'b0);
        check_idle();

        // Back-to-back round robin from ptr=0.
        pulse_reset(3'b000, 1'b1);
        set_ops(0, 32'd1, 32'd2);
        set_ops(1, 32'd10, 32'd20);
        set_ops(2, 32'd100, 32'd200);
        for (int k = 0; k < 2; k++) begin
            step(3'b111, 1'b1, 3'b001, 2'd0, 32'd3, 1'b0, 1'b0);
            step(3'b111, 1'b1, 3'b010, 2'd1, 32'd30, 1'b0, 1'b0);
            step(3'b111, 1'b1, 3'b100, 2'd2, 32'd300, 1'b0, 1'b0);
        end
        step(3'b000, 1'b1, 3'b000, 2'd0, 32'd0, 1'b0, 1'b0);
        check_idle();

        // Carry and signed overflow corners; ptr ends at 2.
        set_ops(0, 32'hFFFF_FFFF, 32'd1);
        step(3'b001, 1'b1, 3'b001, 2'd0, 32'd0, 1'b1, 1'b0);
        set_ops(1, 32'h7FFF_FFFF, 32'd1);
        step(3'b010, 1'b1, 3'b010, 2'd1, 32'h8000_0000, 1'b0, 1'b1);

        // Wrap-around: ptr=2 with 011 grants 0, then ptr=1 grants 1.
        set_ops(0, 32'd3, 32'd4);
        set_ops(1, 32'd40, 32'd2);
        step(3'b011, 1'b1, 3'b001, 2'd0, 32'd7, 1'b0, 1'b0);
        step(3'b011, 1'b1, 3'b010, 2'd1, 32'd42, 1'b0, 1'b0);

        // Back-pressure while FULL, then pass-through drain.
        set_ops(1, 32'h100, 32'h23);
        for (int k = 0; k < 3; k++) hold_step(2'd1, 32'd42);
        step(3'b010, 1'b1, 3'b010, 2'd1, 32'h123, 1'b0, 1'b0);

        // Reset while FULL with requests pending; ptr returns to 0.
        pulse_reset(3'b111, 1'b0);
        step(3'b110, 1'b1, 3'b010, 2'd1, 32'h123, 1'b0, 1'b0);
        step(3'b110, 1'b1, 3'b100, 2'd2, 32'd300, 1'b0, 1'b0);
        step(3'b000, 1'b1, 3'b000, 2'd0, 32'd0, 1'b0, 1'b0);
        check_idle();

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
